// File: rtl/load_value_predictor.sv
// load_value_predictor: PC-indexed last-value predictor answering the hazard controller's value-prediction handshake.
// Latency: vp_en -> pred_valid 2 cycles; dc_valid -> vp_done / vp_lock release 1 cycle; recovery_done -> ack 1 cycle.
// Backpressure: one request in flight, vp_en outside IDLE is dropped. Define VP_TAG_CHECK_EN to store and compare PC tags.
`timescale 1ns/1ps
module load_value_predictor #(
    parameter int ENTRIES     = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vp_en,
    input  logic [ADDR_WIDTH-1:0] vp_pc,
    input  logic                  dc_valid,
    input  logic [DATA_WIDTH-1:0] dc_data,
    input  logic                  recovery_done,
    output logic [DATA_WIDTH-1:0] pred_data,
    output logic                  pred_valid,
    output logic                  vp_lock,
    output logic                  vp_done,
    output logic                  recover,
    output logic                  recovery_done_ack
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CONF_BITS-1:0] CONF_MAX     = '1;
    localparam logic [CONF_BITS-1:0] CONF_MIN_HIT = CONF_BITS'(CONF_THRESH);
    localparam logic [CNT_W-1:0]     CNT_LIMIT    = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_DC,
        S_RECOVER
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pred_data_d;
    logic                  pred_valid_d, vp_lock_d, vp_done_d, recover_d, ack_d;
    logic                  train;
    logic                  tag_match, entry_hit, lookup_hit;

    logic                  tbl_vld  [ENTRIES];
    logic [CONF_BITS-1:0]  tbl_conf [ENTRIES];
    logic [DATA_WIDTH-1:0] tbl_val  [ENTRIES];

`ifdef VP_TAG_CHECK_EN
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    logic [TAG_W-1:0] tbl_tag [ENTRIES];
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             unused_pc;

    assign unused_pc = ^vp_pc[1:0];
    assign tag_match = (tbl_tag[idx_q] == tag_q);
`else
    logic unused_pc;

    // Aliasing PCs share an entry, so any valid entry counts as a tag hit.
    assign unused_pc = ^{vp_pc[ADDR_WIDTH-1:IDX_W+2], vp_pc[1:0]};
    assign tag_match = 1'b1;
`endif

    assign entry_hit  = tbl_vld[idx_q] && tag_match;
    assign lookup_hit = entry_hit && (tbl_conf[idx_q] >= CONF_MIN_HIT);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pred_data_d  = pred_data;
        pred_valid_d = pred_valid;
        vp_lock_d    = vp_lock;
        vp_done_d    = 1'b0;
        recover_d    = recover;
        ack_d        = 1'b0;
        train        = 1'b0;
`ifdef VP_TAG_CHECK_EN
        tag_d        = tag_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (vp_en) begin
                    idx_d   = vp_pc[IDX_W+1:2];
`ifdef VP_TAG_CHECK_EN
                    tag_d   = vp_pc[ADDR_WIDTH-1:IDX_W+2];
`endif
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                cnt_d        = '0;
                state_d      = S_WAIT_DC;
                pred_valid_d = lookup_hit;
                vp_lock_d    = lookup_hit;
                pred_data_d  = lookup_hit ? tbl_val[idx_q] : '0;
            end
            S_WAIT_DC: begin
                // pred_valid doubles as the "this request was predicted" flag.
                if (dc_valid) begin
                    train        = 1'b1;
                    pred_valid_d = 1'b0;
                    pred_data_d  = '0;
                    if (pred_valid && (dc_data != pred_data)) begin
                        recover_d = 1'b1;
                        state_d   = S_RECOVER;
                    end else begin
                        vp_done_d = 1'b1;
                        vp_lock_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    pred_valid_d = 1'b0;
                    pred_data_d  = '0;
                    if (pred_valid) begin
                        recover_d = 1'b1;
                        state_d   = S_RECOVER;
                    end else begin
                        vp_lock_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECOVER: begin
                if (recovery_done) begin
                    ack_d     = 1'b1;
                    recover_d = 1'b0;
                    vp_lock_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            idx_q             <= '0;
            cnt_q             <= '0;
            pred_data         <= '0;
            pred_valid        <= 1'b0;
            vp_lock           <= 1'b0;
            vp_done           <= 1'b0;
            recover           <= 1'b0;
            recovery_done_ack <= 1'b0;
`ifdef VP_TAG_CHECK_EN
            tag_q             <= '0;
`endif
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            cnt_q             <= cnt_d;
            pred_data         <= pred_data_d;
            pred_valid        <= pred_valid_d;
            vp_lock           <= vp_lock_d;
            vp_done           <= vp_done_d;
            recover           <= recover_d;
            recovery_done_ack <= ack_d;
`ifdef VP_TAG_CHECK_EN
            tag_q             <= tag_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_vld[i]  <= 1'b0;
                tbl_conf[i] <= '0;
            end
        end else if (train) begin
            if (entry_hit) begin
                if (tbl_val[idx_q] == dc_data) begin
                    if (tbl_conf[idx_q] != CONF_MAX) begin
                        tbl_conf[idx_q] <= tbl_conf[idx_q] + 1'b1;
                    end
                end else begin
                    tbl_val[idx_q]  <= dc_data;
                    tbl_conf[idx_q] <= '0;
                end
            end else begin
                tbl_vld[idx_q]  <= 1'b1;
                tbl_val[idx_q]  <= dc_data;
                tbl_conf[idx_q] <= '0;
`ifdef VP_TAG_CHECK_EN
                tbl_tag[idx_q]  <= tag_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_load_value_predictor.sv
// Self-checking bench for load_value_predictor: directed scenarios plus randomized loads against a last-value table model.
`timescale 1ns/1ps
module tb_load_value_predictor;

    localparam int ENTRIES     = 64;
    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int CONF_BITS   = 2;
    localparam int CONF_THRESH = 2;
    localparam int TIMEOUT     = 255;
    localparam int IDX_W       = $clog2(ENTRIES);
    localparam int CONF_MAX    = (1 << CONF_BITS) - 1;

    logic                  clk;
    logic                  rst;
    logic                  vp_en;
    logic [ADDR_WIDTH-1:0] vp_pc;
    logic                  dc_valid;
    logic [DATA_WIDTH-1:0] dc_data;
    logic                  recovery_done;
    logic [DATA_WIDTH-1:0] pred_data;
    logic                  pred_valid;
    logic                  vp_lock;
    logic                  vp_done;
    logic                  recover;
    logic                  recovery_done_ack;

    int errors = 0;
    int checks = 0;
    int mutex_err = 0;

    // Reference table: one entry per index, conf as plain integer.
    bit          m_vld  [ENTRIES];
    int unsigned m_tag  [ENTRIES];
    logic [31:0] m_val  [ENTRIES];
    int          m_conf [ENTRIES];

    load_value_predictor #(
        .ENTRIES(ENTRIES), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .CONF_BITS(CONF_BITS), .CONF_THRESH(CONF_THRESH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .vp_en(vp_en), .vp_pc(vp_pc),
        .dc_valid(dc_valid), .dc_data(dc_data), .recovery_done(recovery_done),
        .pred_data(pred_data), .pred_valid(pred_valid), .vp_lock(vp_lock),
        .vp_done(vp_done), .recover(recover), .recovery_done_ack(recovery_done_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((int'(vp_done) + int'(recover) + int'(recovery_done_ack)) > 1) mutex_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_tagok(input logic [31:0] pc);
`ifdef VP_TAG_CHECK_EN
        return m_tag[midx(pc)] == (pc >> (IDX_W + 2));
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit m_predicts(input logic [31:0] pc);
        int i = midx(pc);
        return m_vld[i] && m_tagok(pc) && (m_conf[i] >= CONF_THRESH);
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic [31:0] d);
        int i = midx(pc);
        if (m_vld[i] && m_tagok(pc)) begin
            if (m_val[i] == d) begin
                if (m_conf[i] < CONF_MAX) m_conf[i]++;
            end else begin
                m_val[i]  = d;
                m_conf[i] = 0;
            end
        end else begin
            m_vld[i]  = 1'b1;
            m_tag[i]  = pc >> (IDX_W + 2);
            m_val[i]  = d;
            m_conf[i] = 0;
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_vld[i]  = 1'b0;
            m_conf[i] = 0;
        end
    endfunction

    // One complete request: lookup, optional wait, D-cache return, optional recovery.
    task automatic do_load(input logic [31:0] pc, input int delay, input logic [31:0] data, input int rec_delay);
        bit          exp_pred;
        bit          mis;
        logic [31:0] exp_val;
        exp_pred = m_predicts(pc);
        exp_val  = m_val[midx(pc)];
        vp_en = 1'b1; vp_pc = pc;
        tick();
        vp_en = 1'b0;
        checks++; if (pred_valid !== 1'b0 || vp_lock !== 1'b0) begin errors++; $display("FAIL lookup_quiet pc=%h: pred_valid=%b vp_lock=%b want 0 0", pc, pred_valid, vp_lock); end
        tick();
        checks++; if (pred_valid !== exp_pred) begin errors++; $display("FAIL pred_valid pc=%h: got %b want %b", pc, pred_valid, exp_pred); end
        checks++; if (vp_lock !== exp_pred) begin errors++; $display("FAIL vp_lock pc=%h: got %b want %b", pc, vp_lock, exp_pred); end
        if (exp_pred) begin
            checks++; if (pred_data !== exp_val) begin errors++; $display("FAIL pred_data pc=%h: got %h want %h", pc, pred_data, exp_val); end
        end
        for (int k = 0; k < delay; k++) begin
            tick();
            checks++; if (vp_lock !== exp_pred || pred_valid !== exp_pred || vp_done !== 1'b0) begin errors++; $display("FAIL wait_stable pc=%h: lock=%b pv=%b done=%b want %b %b 0", pc, vp_lock, pred_valid, vp_done, exp_pred, exp_pred); end
        end
        mis = exp_pred && (data != exp_val);
        dc_valid = 1'b1; dc_data = data;
        tick();
        dc_valid = 1'b0;
        m_train(pc, data);
        if (!mis) begin
            checks++; if (vp_done !== 1'b1 || vp_lock !== 1'b0 || pred_valid !== 1'b0 || recover !== 1'b0) begin errors++; $display("FAIL retire pc=%h: done=%b lock=%b pv=%b rec=%b want 1 0 0 0", pc, vp_done, vp_lock, pred_valid, recover); end
            tick();
            checks++; if (vp_done !== 1'b0) begin errors++; $display("FAIL done_width pc=%h: got %b want 0", pc, vp_done); end
        end else begin
            checks++; if (recover !== 1'b1 || vp_lock !== 1'b1 || pred_valid !== 1'b0 || vp_done !== 1'b0) begin errors++; $display("FAIL mispredict pc=%h: rec=%b lock=%b pv=%b done=%b want 1 1 0 0", pc, recover, vp_lock, pred_valid, vp_done); end
            for (int k = 0; k < rec_delay; k++) begin
                tick();
                checks++; if (recover !== 1'b1 || vp_lock !== 1'b1) begin errors++; $display("FAIL recover_hold pc=%h: rec=%b lock=%b want 1 1", pc, recover, vp_lock); end
            end
            recovery_done = 1'b1;
            tick();
            recovery_done = 1'b0;
            checks++; if (recovery_done_ack !== 1'b1 || recover !== 1'b0 || vp_lock !== 1'b0) begin errors++; $display("FAIL recovery_ack pc=%h: ack=%b rec=%b lock=%b want 1 0 0", pc, recovery_done_ack, recover, vp_lock); end
            tick();
            checks++; if (recovery_done_ack !== 1'b0) begin errors++; $display("FAIL ack_width pc=%h: got %b want 0", pc, recovery_done_ack); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vp_en = 1'b0; vp_pc = '0; dc_valid = 1'b0; dc_data = '0; recovery_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_reset();
        checks++; if (pred_data !== '0) begin errors++; $display("FAIL reset_pred_data: got %h want 0", pred_data); end
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_pred_valid: got %b want 0", pred_valid); end
        checks++; if (vp_lock !== 1'b0) begin errors++; $display("FAIL reset_vp_lock: got %b want 0", vp_lock); end
        checks++; if (vp_done !== 1'b0) begin errors++; $display("FAIL reset_vp_done: got %b want 0", vp_done); end
        checks++; if (recover !== 1'b0) begin errors++; $display("FAIL reset_recover: got %b want 0", recover); end
        checks++; if (recovery_done_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", recovery_done_ack); end
    endtask

    task automatic test_cold_miss();
        do_load(32'h400, 3, 32'h1234, 0);
    endtask

    task automatic test_confidence();
        for (int n = 0; n < 3; n++) do_load(32'h400, 1, 32'h1234, 0);
    endtask

    task automatic test_mispredict();
        do_load(32'h400, 2, 32'h5678, 4);
        do_load(32'h400, 1, 32'h5678, 0);
    endtask

    task automatic test_timeout();
        int cyc;
        int done_seen;
        bit exp_pred;
        for (int n = 0; n < 3; n++) do_load(32'h404, 1, 32'hABCD, 0);
        exp_pred = m_predicts(32'h404);
        vp_en = 1'b1; vp_pc = 32'h404;
        tick();
        vp_en = 1'b0;
        tick();
        checks++; if (pred_valid !== exp_pred) begin errors++; $display("FAIL timeout_pred: got %b want %b", pred_valid, exp_pred); end
        cyc = 0;
        while (cyc < TIMEOUT + 20 && recover !== 1'b1) begin tick(); cyc++; end
        checks++; if (recover !== 1'b1) begin errors++; $display("FAIL timeout_recover: got %b want 1", recover); end
        checks++; if (cyc !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TIMEOUT + 1); end
        checks++; if (vp_lock !== 1'b1 || pred_valid !== 1'b0) begin errors++; $display("FAIL timeout_lock: lock=%b pv=%b want 1 0", vp_lock, pred_valid); end
        recovery_done = 1'b1;
        tick();
        recovery_done = 1'b0;
        checks++; if (recovery_done_ack !== 1'b1 || vp_lock !== 1'b0) begin errors++; $display("FAIL timeout_ack: ack=%b lock=%b want 1 0", recovery_done_ack, vp_lock); end
        tick();
        do_load(32'h404, 2, 32'hABCD, 0);
        vp_en = 1'b1; vp_pc = 32'h808;
        tick();
        vp_en = 1'b0;
        tick();
        done_seen = 0;
        for (int k = 0; k < TIMEOUT + 1; k++) begin
            tick();
            if (vp_done === 1'b1 || recover === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL timeout_silent: got %0d pulses want 0", done_seen); end
        checks++; if (vp_lock !== 1'b0) begin errors++; $display("FAIL timeout_unlocked: got %b want 0", vp_lock); end
        do_load(32'h808, 0, 32'h42, 0);
    endtask

    task automatic test_back_to_back();
        vp_en = 1'b1; vp_pc = 32'h40C;
        tick();
        vp_en = 1'b0;
        dc_valid = 1'b1; dc_data = 32'h9999;
        tick();
        dc_valid = 1'b0;
        checks++; if (vp_done !== 1'b0 || vp_lock !== 1'b0) begin errors++; $display("FAIL lookup_dc_ignored: done=%b lock=%b want 0 0", vp_done, vp_lock); end
        tick();
        vp_en = 1'b1; vp_pc = 32'h800;
        tick();
        vp_en = 1'b0;
        checks++; if (vp_done !== 1'b0) begin errors++; $display("FAIL busy_vp_en: done=%b want 0", vp_done); end
        dc_valid = 1'b1; dc_data = 32'h1111;
        tick();
        dc_valid = 1'b0;
        m_train(32'h40C, 32'h1111);
        checks++; if (vp_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", vp_done); end
        tick();
        recovery_done = 1'b1;
        tick();
        recovery_done = 1'b0;
        checks++; if (recovery_done_ack !== 1'b0) begin errors++; $display("FAIL stray_recovery_done: ack=%b want 0", recovery_done_ack); end
        tick();
        do_load(32'h800, 1, 32'h2222, 0);
        do_load(32'h40C, 0, 32'h1111, 0);
    endtask

    task automatic test_random();
        logic [31:0] pcs [4];
        logic [31:0] pc;
        logic [31:0] d;
        pcs[0] = 32'h400; pcs[1] = 32'h500; pcs[2] = 32'h404; pcs[3] = 32'h408;
        for (int n = 0; n < 60; n++) begin
            pc = pcs[$urandom_range(0, 3)];
            d  = ($urandom_range(0, 3) == 0) ? 32'h5678 : 32'h1234;
            do_load(pc, int'($urandom_range(0, 4)), d, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_in_recover();
        for (int n = 0; n < 3; n++) do_load(32'h410, 0, 32'h77, 0);
        vp_en = 1'b1; vp_pc = 32'h410;
        tick();
        vp_en = 1'b0;
        tick();
        checks++; if (pred_valid !== m_predicts(32'h410)) begin errors++; $display("FAIL rr_pred: got %b want %b", pred_valid, m_predicts(32'h410)); end
        dc_valid = 1'b1; dc_data = 32'h78;
        tick();
        dc_valid = 1'b0;
        m_train(32'h410, 32'h78);
        checks++; if (recover !== 1'b1) begin errors++; $display("FAIL rr_recover: got %b want 1", recover); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        checks++; if ({pred_data, pred_valid, vp_lock, vp_done, recover, recovery_done_ack} !== '0) begin errors++; $display("FAIL rr_outputs: pd=%h pv=%b lock=%b done=%b rec=%b ack=%b want all 0", pred_data, pred_valid, vp_lock, vp_done, recover, recovery_done_ack); end
        tick();
        checks++; if (recover !== 1'b0 || recovery_done_ack !== 1'b0) begin errors++; $display("FAIL rr_no_recover: rec=%b ack=%b want 0 0", recover, recovery_done_ack); end
        do_load(32'h410, 1, 32'h78, 0);
    endtask

    task automatic test_mutex();
        checks++; if (mutex_err !== 0) begin errors++; $display("FAIL pulse_exclusive: %0d overlapping cycles want 0", mutex_err); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_confidence();
        test_mispredict();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_in_recover();
        test_mutex();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_value_predictor.md
Name: load_value_predictor

Overview:
- Responder end of the value-prediction handshake issued by the hazard controller.
- On a load request (vp_en + load PC) it looks up a PC-indexed last-value table with per-entry confidence counters.
- When confident, it returns a predicted value and holds vp_lock while the D-cache resolves the real value.
- On mismatch it requests pipeline/register-snapshot recovery and waits for the recovery handshake to complete.

Parameters:
- ENTRIES, 64, last-value table depth; power of two, ≥4.
- DATA_WIDTH, 32, load data width.
- ADDR_WIDTH, 32, PC width.
- CONF_BITS, 2, saturating confidence counter width.
- CONF_THRESH, 2, minimum confidence to issue a prediction.
- TIMEOUT, 255, max cycles waiting for D-cache data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- vp_en  in  1  load prediction request (single-cycle pulse).
- vp_pc  in  ADDR_WIDTH  PC of requesting load; valid with vp_en.
- dc_valid  in  1  D-cache returned actual load data.
- dc_data  in  DATA_WIDTH  actual load data, valid with dc_valid.
- recovery_done  in  1  snapshot restore and pipeline flush complete.
- pred_data  out  DATA_WIDTH  predicted value.
- pred_valid  out  1  pred_data is a confident prediction.
- vp_lock  out  1  speculation outstanding; hazard controller blocks further loads/stores.
- vp_done  out  1  one-cycle pulse: request retired without recovery.
- recover  out  1  misprediction; restore register snapshot and flush.
- recovery_done_ack  out  1  one-cycle pulse acknowledging recovery_done.

Behaviour:
- Reset (rst high at posedge): state IDLE; all table valid bits, confidences and the timeout counter cleared. Every output is 0, including pred_data. Reset mid-operation aborts any speculation with no recover pulse.
- Table index = vp_pc[log2(ENTRIES)+1:2]. Each entry holds valid, tag, value and conf.
- IDLE:
  - vp_en=1: latch pc, go to LOOKUP.
  - vp_en while not IDLE: ignored, no table side effect.
- LOOKUP (1 cycle):
  - hit = valid & tag match & conf ≥ CONF_THRESH.
  - Hit: next cycle pred_valid=1, pred_data=value, vp_lock=1. These stay stable until leaving WAIT_DC.
  - Miss: pred_valid=0, vp_lock=0.
  - Either way, go to WAIT_DC with the timeout counter cleared.
- WAIT_DC:
  - Counter increments each cycle without dc_valid.
  - On dc_valid, train the table:
    - Tag hit, value equal: conf saturating +1.
    - Tag hit, value differs: value=dc_data, conf=0.
    - Tag miss or invalid: allocate (valid=1, tag, value=dc_data, conf=0).
  - Then by prediction outcome:
    - Predicted and equal: vp_done pulse, drop vp_lock/pred_valid, go to IDLE.
    - Predicted and differs: go to RECOVER.
    - Not predicted: vp_done pulse, go to IDLE.
  - dc_valid in the same cycle as LOOKUP is ignored. dc_valid is only sampled in WAIT_DC.
- Timeout (counter = TIMEOUT, no dc_valid): no training.
  - Predicted: go to RECOVER.
  - Otherwise: go to IDLE with no vp_done.
- RECOVER:
  - recover=1 and vp_lock=1 held; pred_valid=0.
  - On recovery_done: next cycle recovery_done_ack=1 for exactly 1 cycle, recover=0, vp_lock=0, state IDLE.
  - recovery_done outside RECOVER is ignored.
- Latencies:
  - vp_en to pred_valid: 2 cycles.
  - dc_valid (match) to vp_lock deassert: 1 cycle.
  - vp_done, recover and recovery_done_ack are mutually exclusive in any cycle.

Optional Feature:
- Macro VP_TAG_CHECK_EN.
  - Defined: tag = vp_pc[ADDR_WIDTH-1:log2(ENTRIES)+2], stored and compared on lookup and training.
  - Undefined: no tag storage; hit = valid & conf ≥ CONF_THRESH. Aliasing PCs share an entry, and training treats a valid entry as a tag hit.

Test Plan:
- Cold table, vp_en with pc=0x400, dc_data=0x1234 after 3 cycles -> pred_valid=0, vp_lock=0, vp_done pulse; entry allocated with conf=0.
- Same pc three times with 0x1234 -> third request gives pred_valid=1, pred_data=0x1234, vp_lock=1. On matching dc_valid: vp_done pulse, lock drops 1 cycle later.
- Confident entry, dc_data=0x5678 -> recover=1 held. recovery_done after 4 cycles -> recovery_done_ack for 1 cycle, vp_lock=0. Entry value becomes 0x5678, conf=0, so the next request is not predicted.
- Confident entry, no dc_valid for TIMEOUT cycles -> recover asserted, table unchanged.
- Second vp_en during WAIT_DC with pc=0x800 -> ignored; the 0x800 entry stays invalid.
- rst during RECOVER -> next cycle all outputs 0, state IDLE. A subsequent request on the trained pc is not predicted.
